// File: rtl/gb_wr_sched.sv
// Global-buffer write scheduler: round-robin grant among empty banks, then streams one burst into the granted bank.
// Each accepted beat is written one cycle later; din_vld gaps stall the burst indefinitely, start aborts from any state.
module gb_wr_sched #(
  parameter int NUM_SRAM   = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int PORT_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_SRAM-1:0]   wr_req_vec,
  input  logic                  burst_vld,
  input  logic [ADDR_WIDTH-1:0] burst_len,
  output logic                  burst_rdy,
  input  logic                  din_vld,
  input  logic [PORT_WIDTH-1:0] din,
  output logic                  din_rdy,
  output logic [1:0]            State_Wr,
  output logic [5:0]            SRAMIF_Wr_ID,
  output logic                  IFSRAM_Conf_rdy,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [PORT_WIDTH-1:0] data_in,
  output logic                  write_SRAM_done
);
  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] REQ_READY = 2'b01;
  localparam logic [1:0] WRITE     = 2'b11;
  localparam int         CW        = ADDR_WIDTH + 1;

  logic [1:0]    state;
  logic [3:0]    rr_ptr;
  logic [3:0]    bank_id;
  logic [3:0]    grant_idx;
  logic [3:0]    next_ptr;
  logic [4:0]    cand;
  logic          grant_found;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] len_q;
  logic          burst_go;
  logic          din_go;
  logic          accept;
  logic          last_beat;

  // Search starts at rr_ptr and wraps; cand never exceeds 2*NUM_SRAM-2.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_SRAM; i++) begin
      cand = {1'b0, rr_ptr} + 5'(i);
      if (cand >= 5'(NUM_SRAM)) cand = cand - 5'(NUM_SRAM);
      if (!grant_found && wr_req_vec[cand[3:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[3:0];
      end
    end
  end

  // Internal handshakes exclude rst_n so the reset net stays purely asynchronous.
  assign burst_go  = (state == IDLE) && !start && burst_vld && grant_found;
  assign din_go    = (state == WRITE) && !start;
  assign burst_rdy = rst_n && burst_go;
  assign din_rdy   = rst_n && din_go;
  assign accept    = din_go && din_vld;
  assign last_beat = (beat_cnt == len_q - CW'(1));
  assign next_ptr  = (bank_id == 4'(NUM_SRAM - 1)) ? 4'd0 : bank_id + 4'd1;

  assign State_Wr     = state;
  assign SRAMIF_Wr_ID = {2'b00, bank_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      beat_cnt        <= '0;
      len_q           <= '0;
      bank_id         <= '0;
      IFSRAM_Conf_rdy <= 1'b0;
      write_en        <= 1'b0;
      addr_w          <= '0;
      data_in         <= '0;
      write_SRAM_done <= 1'b0;
    end else if (start) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      beat_cnt        <= '0;
      IFSRAM_Conf_rdy <= 1'b0;
      write_en        <= 1'b0;
      write_SRAM_done <= 1'b0;
    end else begin
      IFSRAM_Conf_rdy <= burst_go;
      write_en        <= accept;
      write_SRAM_done <= accept && last_beat;
      case (state)
        IDLE: begin
          if (burst_go) begin
            state    <= REQ_READY;
            bank_id  <= grant_idx;
            beat_cnt <= '0;
            len_q    <= (burst_len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, burst_len};
          end
        end
        REQ_READY: state <= WRITE;
        WRITE: begin
          if (accept) begin
            addr_w   <= beat_cnt[ADDR_WIDTH-1:0];
            data_in  <= din;
            beat_cnt <= beat_cnt + CW'(1);
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gb_wr_sched.sv
// Bench for gb_wr_sched: grant table, directed burst sequences, and random bursts against a transaction-level model.
module tb_gb_wr_sched;
  localparam int N  = 16;
  localparam int AW = 9;
  localparam int PW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  wr_req_vec;
  logic          burst_vld;
  logic [AW-1:0] burst_len;
  logic          burst_rdy;
  logic          din_vld;
  logic [PW-1:0] din;
  logic          din_rdy;
  logic [1:0]    State_Wr;
  logic [5:0]    SRAMIF_Wr_ID;
  logic          IFSRAM_Conf_rdy;
  logic          write_en;
  logic [AW-1:0] addr_w;
  logic [PW-1:0] data_in;
  logic          write_SRAM_done;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  typedef struct {
    int         setup;    // bank of a len-1 burst run first to move the pointer, -1 for none
    logic [N-1:0] vec;
    logic       vld;
    logic       st;
    logic       exp_rdy;
    int         exp_id;
  } vec_t;
  vec_t tbl[12];
  int rr_exp[4];

  gb_wr_sched #(.NUM_SRAM(N), .ADDR_WIDTH(AW), .PORT_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_req_vec(wr_req_vec),
    .burst_vld(burst_vld), .burst_len(burst_len), .burst_rdy(burst_rdy),
    .din_vld(din_vld), .din(din), .din_rdy(din_rdy), .State_Wr(State_Wr),
    .SRAMIF_Wr_ID(SRAMIF_Wr_ID), .IFSRAM_Conf_rdy(IFSRAM_Conf_rdy),
    .write_en(write_en), .addr_w(addr_w), .data_in(data_in),
    .write_SRAM_done(write_SRAM_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  function automatic logic [PW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // First requesting bank at or after ptr, wrapping around the bank set.
  function automatic int model_grant(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1; burst_vld = 1'b0; din_vld = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    model_ptr = 0;
  endtask

  task automatic run_burst(input logic [N-1:0] vec, input logic [AW-1:0] len, input int gap_pct,
                           input logic [7:0] pat, input int pat_n, input int abort_after,
                           output int gid, output int nwr);
    int eff, exp_id, accepted, budget, post, cyc;
    logic acc_prev, done_seen, aborted, fin;
    logic [PW-1:0] dq[$];
    eff    = (len == '0) ? (1 << AW) : int'(len);
    exp_id = model_grant(model_ptr, vec);
    gid = -1;
    nwr = 0;
    @(posedge clk); #1;
    start = 1'b0; burst_vld = 1'b1; wr_req_vec = vec; burst_len = len; din_vld = 1'b1; din = rnd128();
    @(negedge clk);
    chk("grant_rdy", burst_rdy, 1);
    chk("grant_state_idle", State_Wr, 2'b00);
    chk("grant_din_rdy_low", din_rdy, 0);
    chk("idle_no_done", write_SRAM_done, 0);
    chk("idle_no_wen", write_en, 0);
    if (burst_rdy !== 1'b1) begin
      burst_vld = 1'b0;
      din_vld = 1'b0;
      return;
    end
    @(posedge clk); #1;
    wr_req_vec = N'($urandom);
    @(negedge clk);
    chk("conf_state", State_Wr, 2'b01);
    chk("conf_rdy", IFSRAM_Conf_rdy, 1);
    chk("grant_id", SRAMIF_Wr_ID, exp_id);
    chk("conf_no_burst_rdy", burst_rdy, 0);
    chk("conf_no_din_rdy", din_rdy, 0);
    gid = int'(SRAMIF_Wr_ID);
    acc_prev = 1'b0; accepted = 0; done_seen = 1'b0; aborted = 1'b0; fin = 1'b0;
    post = 0; cyc = 0;
    budget = eff * 20 + 64;
    while (!fin) begin
      @(posedge clk); #1;
      burst_vld = 1'b0;
      start = 1'b0;
      if (abort_after >= 0 && !aborted && accepted == abort_after) begin
        start = 1'b1;
        aborted = 1'b1;
      end
      if (pat_n > 0) din_vld = (cyc < pat_n) ? pat[cyc] : 1'b1;
      else           din_vld = ($urandom_range(0, 99) >= gap_pct);
      din = rnd128();
      @(negedge clk);
      chk("wen_follows_accept", write_en, acc_prev);
      chk("no_conf_in_burst", IFSRAM_Conf_rdy, 0);
      if (write_en) begin
        if (nwr < dq.size()) chk("data", data_in, dq[nwr]);
        else fail($sformatf("extra_write: got write index %0d, expected fewer than %0d", nwr, dq.size()));
        chk("addr", addr_w, nwr);
        chk("done_on_last", write_SRAM_done, nwr == eff - 1);
        if (write_SRAM_done) begin
          chk("done_din_rdy_low", din_rdy, 0);
          chk("done_state_idle", State_Wr, 2'b00);
          chk("id_hold", SRAMIF_Wr_ID, exp_id);
          done_seen = 1'b1;
        end
        nwr++;
      end else begin
        chk("no_done_without_wen", write_SRAM_done, 0);
      end
      if (aborted) begin
        if (post == 0) chk("abort_cycle_din_rdy", din_rdy, 0);
        else           chk("abort_state_idle", State_Wr, 2'b00);
        post++;
        if (post >= 4) fin = 1'b1;
      end
      acc_prev = din_vld & din_rdy;
      if (acc_prev) begin
        dq.push_back(din);
        accepted++;
      end
      if (done_seen) fin = 1'b1;
      cyc++;
      if (!fin && cyc > budget) begin
        fail($sformatf("burst_timeout: got %0d writes after %0d cycles, expected %0d", nwr, cyc, eff));
        fin = 1'b1;
      end
    end
    din_vld = 1'b0;
    if (aborted)        model_ptr = 0;
    else if (done_seen) model_ptr = (exp_id + 1) % N;
  endtask

  initial begin
    int g, w;
    tbl[0]  = '{-1, 16'h0001, 1'b1, 1'b0, 1'b1, 0};
    tbl[1]  = '{-1, 16'h0000, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{-1, 16'h8000, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{-1, 16'h0F00, 1'b1, 1'b1, 1'b0, 0};
    tbl[4]  = '{-1, 16'h8081, 1'b1, 1'b0, 1'b1, 0};
    tbl[5]  = '{ 0, 16'h8081, 1'b1, 1'b0, 1'b1, 7};
    tbl[6]  = '{ 7, 16'h8081, 1'b1, 1'b0, 1'b1, 15};
    tbl[7]  = '{15, 16'h8081, 1'b1, 1'b0, 1'b1, 0};
    tbl[8]  = '{ 3, 16'h0018, 1'b1, 1'b0, 1'b1, 4};
    tbl[9]  = '{ 5, 16'h0011, 1'b1, 1'b0, 1'b1, 0};
    tbl[10] = '{15, 16'hFFFF, 1'b1, 1'b0, 1'b1, 0};
    tbl[11] = '{ 9, 16'h0200, 1'b1, 1'b0, 1'b1, 9};
    rr_exp = '{0, 7, 15, 0};

    // Reset with active-looking inputs: everything must stay quiet.
    rst_n = 1'b0; start = 1'b0; burst_vld = 1'b1; wr_req_vec = '1; burst_len = 4;
    din_vld = 1'b1; din = '1;
    #12;
    chk("rst_burst_rdy", burst_rdy, 0);
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_state", State_Wr, 2'b00);
    chk("rst_id", SRAMIF_Wr_ID, 0);
    chk("rst_conf", IFSRAM_Conf_rdy, 0);
    chk("rst_wen", write_en, 0);
    chk("rst_addr", addr_w, 0);
    chk("rst_data", data_in, 0);
    chk("rst_done", write_SRAM_done, 0);
    @(negedge clk);
    rst_n = 1'b1; burst_vld = 1'b0; din_vld = 1'b0;

    for (int t = 0; t < 12; t++) begin
      pulse_start();
      if (tbl[t].setup >= 0) run_burst(N'(1) << tbl[t].setup, 1, 0, 8'h0, 0, -1, g, w);
      @(posedge clk); #1;
      burst_vld = tbl[t].vld; wr_req_vec = tbl[t].vec; start = tbl[t].st;
      burst_len = 1; din_vld = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_burst_rdy", t), burst_rdy, tbl[t].exp_rdy);
      @(posedge clk); #1;
      burst_vld = 1'b0; start = 1'b0;
      @(negedge clk);
      if (tbl[t].exp_rdy) begin
        chk($sformatf("tbl%0d_id", t), SRAMIF_Wr_ID, tbl[t].exp_id);
        chk($sformatf("tbl%0d_conf", t), IFSRAM_Conf_rdy, 1);
      end else begin
        chk($sformatf("tbl%0d_stay_idle", t), State_Wr, 2'b00);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_end_idle", t), State_Wr, 2'b00);
      din_vld = 1'b0;
    end

    // Basic 4-beat burst on bank 0
    pulse_start();
    run_burst(16'h0001, 4, 0, 8'h0, 0, -1, g, w);
    chk("basic_id", g, 0);
    chk("basic_writes", w, 4);

    // Round robin over banks 0, 7, 15 then wrap
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      run_burst(16'h8081, 1, 0, 8'h0, 0, -1, g, w);
      chk($sformatf("rr_id%0d", k), g, rr_exp[k]);
    end

    // Length 0 means a full bank
    run_burst(16'h0004, 0, 0, 8'h0, 0, -1, g, w);
    chk("maxlen_writes", w, 1 << AW);

    // Stalled data: din_vld = 1,0,0,1,1
    run_burst(16'h0010, 3, 0, 8'b0001_1001, 5, -1, g, w);
    chk("stall_writes", w, 3);

    // Abort after two beats, then the search restarts at bank 0
    pulse_start();
    run_burst(16'h0020, 8, 0, 8'h0, 0, 2, g, w);
    chk("abort_writes", w, 2);
    run_burst(16'h0101, 1, 0, 8'h0, 0, -1, g, w);
    chk("abort_next_id", g, 0);

    // No bank free: offer stays pending until a request bit rises
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      burst_vld = 1'b1; wr_req_vec = '0; burst_len = 2;
      @(negedge clk);
      chk("nobank_burst_rdy", burst_rdy, 0);
      chk("nobank_state", State_Wr, 2'b00);
    end
    run_burst(16'h0040, 2, 0, 8'h0, 0, -1, g, w);
    chk("nobank_then_id", g, 6);

    // Asynchronous reset in the middle of a burst
    pulse_start();
    @(posedge clk); #1;
    burst_vld = 1'b1; wr_req_vec = 16'h0002; burst_len = 8; din_vld = 1'b1;
    @(posedge clk); #1;
    burst_vld = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", State_Wr, 2'b00);
    chk("midrst_wen", write_en, 0);
    chk("midrst_din_rdy", din_rdy, 0);
    chk("midrst_id", SRAMIF_Wr_ID, 0);
    chk("midrst_addr", addr_w, 0);
    @(negedge clk);
    rst_n = 1'b1; din_vld = 1'b0;
    model_ptr = 0;
    run_burst(16'h0006, 2, 0, 8'h0, 0, -1, g, w);
    chk("midrst_next_id", g, 1);

    // Random bursts against the transaction model
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] v;
      int l, ab, gap;
      v = N'($urandom) & N'($urandom) & N'($urandom);
      if (v == '0) v = N'(1) << $urandom_range(0, N - 1);
      l   = $urandom_range(1, 24);
      ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, l - 1) : -1;
      gap = $urandom_range(0, 60);
      run_burst(v, AW'(l), gap, 8'h0, 0, ab, g, w);
      if (ab < 0) chk("rand_writes", w, l);
      else        chk("rand_abort_writes", w, ab);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
